// File: rtl/imager_stream_gen.sv
// Imager test-pattern stream generator.
// Emits framed word streams (FRAME_START, ROW_START, pixels, ROW_END,
// FRAME_END) with programmable geometry, blanking and test patterns.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH       4
`define DTYPE_NONE        4'd0
`define DTYPE_FRAME_START 4'd1
`define DTYPE_FRAME_END   4'd2
`define DTYPE_ROW_START   4'd3
`define DTYPE_ROW_END     4'd4
`define DTYPE_PIXEL       4'd5
`endif

module imager_stream_gen #(
   parameter int PIXEL_WIDTH = 8,
   parameter int DIM_WIDTH   = 11,
   parameter int NUM_ROWS    = 728,
   parameter int NUM_COLS    = 1286
) (
   input  logic                    clk,
   input  logic                    reset_clk,
   input  logic                    enable,
   input  logic [DIM_WIDTH-1:0]    num_rows,
   input  logic [DIM_WIDTH-1:0]    num_cols,
   input  logic [15:0]             hblank,
   input  logic [15:0]             vblank,
   input  logic [1:0]              pattern_sel,
   input  logic [PIXEL_WIDTH-1:0]  flat_value,
   output logic                    dvo,
   output logic [`DTYPE_WIDTH-1:0] dtypeo,
   output logic [15:0]             datao,
   output logic [15:0]             frame_count,
   output logic                    busy
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FSTART = 3'd1,
      ST_RSTART = 3'd2,
      ST_PIXELS = 3'd3,
      ST_REND   = 3'd4,
      ST_HBLANK = 3'd5,
      ST_FEND   = 3'd6,
      ST_VBLANK = 3'd7
   } state_t;

   localparam logic [DIM_WIDTH-1:0] DIM_ZERO = {DIM_WIDTH{1'b0}};
   localparam logic [DIM_WIDTH-1:0] DIM_ONE  = {{(DIM_WIDTH-1){1'b0}}, 1'b1};

   state_t                  state_r, state_s;
   logic [DIM_WIDTH-1:0]    col_r, col_s;
   logic [DIM_WIDTH-1:0]    row_r, row_s;
   logic [15:0]             blank_r, blank_s;
   logic [DIM_WIDTH-1:0]    rows_r, cols_r;
   logic [15:0]             hblank_r, vblank_r;
   logic [1:0]              pattern_r;
   logic [PIXEL_WIDTH-1:0]  flat_r;
   logic [15:0]             frame_count_r;
   logic                    dvo_r, dvo_s;
   logic [`DTYPE_WIDTH-1:0] dtype_r, dtype_s;
   logic [15:0]             data_r, data_s;
   logic                    busy_r, busy_s;

   // Pixel value for the selected pattern, zero-extended to the 16-bit payload.
   function automatic logic [15:0] pixel_value(
      input logic [1:0]             sel,
      input logic [PIXEL_WIDTH-1:0] flat,
      input logic [PIXEL_WIDTH-1:0] col,
      input logic [PIXEL_WIDTH-1:0] row,
      input logic [PIXEL_WIDTH-1:0] fcount
   );
      logic [PIXEL_WIDTH-1:0] pix;
      case (sel)
         2'd0:    pix = flat;
         2'd1:    pix = col;
         2'd2:    pix = row;
         default: pix = col + row + fcount;
      endcase
      return 16'(pix);
   endfunction

   // Next-state, counter and next-output decode; outputs are registered from these.
   always_comb begin
      state_s = state_r;
      col_s   = col_r;
      row_s   = row_r;
      blank_s = blank_r;
      case (state_r)
         ST_IDLE: begin
            if (enable) state_s = ST_FSTART;
            else        state_s = ST_IDLE;
         end
         ST_FSTART: begin
            state_s = ST_RSTART;
            row_s   = DIM_ZERO;
            col_s   = DIM_ZERO;
         end
         ST_RSTART: begin
            state_s = ST_PIXELS;
            col_s   = DIM_ZERO;
         end
         ST_PIXELS: begin
            if (col_r == cols_r - DIM_ONE) state_s = ST_REND;
            else                           col_s   = col_r + DIM_ONE;
         end
         ST_REND: begin
            if (row_r == rows_r - DIM_ONE) begin
               state_s = ST_FEND;
            end else begin
               row_s = row_r + DIM_ONE;
               if (hblank_r == 16'd0) begin
                  state_s = ST_RSTART;
               end else begin
                  state_s = ST_HBLANK;
                  blank_s = hblank_r;
               end
            end
         end
         ST_HBLANK: begin
            if (blank_r <= 16'd1) begin
               state_s = ST_RSTART;
               blank_s = 16'd0;
            end else begin
               blank_s = blank_r - 16'd1;
            end
         end
         ST_FEND: begin
            if (vblank_r == 16'd0) begin
               state_s = enable ? ST_FSTART : ST_IDLE;
            end else begin
               state_s = ST_VBLANK;
               blank_s = vblank_r;
            end
         end
         ST_VBLANK: begin
            if (blank_r <= 16'd1) begin
               state_s = enable ? ST_FSTART : ST_IDLE;
               blank_s = 16'd0;
            end else begin
               blank_s = blank_r - 16'd1;
            end
         end
         default: state_s = ST_IDLE;
      endcase

      dvo_s   = 1'b0;
      dtype_s = `DTYPE_NONE;
      data_s  = 16'd0;
      busy_s  = (state_s != ST_IDLE);
      case (state_s)
         ST_FSTART: begin dvo_s = 1'b1; dtype_s = `DTYPE_FRAME_START; end
         ST_RSTART: begin dvo_s = 1'b1; dtype_s = `DTYPE_ROW_START;   end
         ST_REND:   begin dvo_s = 1'b1; dtype_s = `DTYPE_ROW_END;     end
         ST_FEND:   begin dvo_s = 1'b1; dtype_s = `DTYPE_FRAME_END;   end
         ST_PIXELS: begin
            dvo_s   = 1'b1;
            dtype_s = `DTYPE_PIXEL;
            data_s  = pixel_value(pattern_r, flat_r, col_s[PIXEL_WIDTH-1:0],
                                  row_s[PIXEL_WIDTH-1:0],
                                  frame_count_r[PIXEL_WIDTH-1:0]);
         end
         default: begin dvo_s = 1'b0; dtype_s = `DTYPE_NONE; end
      endcase
   end

   // State, counters, frame counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset_clk) begin
         state_r       <= ST_IDLE;
         col_r         <= DIM_ZERO;
         row_r         <= DIM_ZERO;
         blank_r       <= 16'd0;
         frame_count_r <= 16'd0;
         dvo_r         <= 1'b0;
         dtype_r       <= `DTYPE_NONE;
         data_r        <= 16'd0;
         busy_r        <= 1'b0;
      end else begin
         state_r <= state_s;
         col_r   <= col_s;
         row_r   <= row_s;
         blank_r <= blank_s;
         dvo_r   <= dvo_s;
         dtype_r <= dtype_s;
         data_r  <= data_s;
         busy_r  <= busy_s;
         if (state_r == ST_FEND) frame_count_r <= frame_count_r + 16'd1;
      end
   end

   // Frame configuration captured in FSTART so the whole frame sees stable settings.
   always_ff @(posedge clk) begin
      if (reset_clk) begin
         rows_r    <= DIM_ZERO;
         cols_r    <= DIM_ZERO;
         hblank_r  <= 16'd0;
         vblank_r  <= 16'd0;
         pattern_r <= 2'd0;
         flat_r    <= {PIXEL_WIDTH{1'b0}};
      end else if (state_r == ST_FSTART) begin
         rows_r    <= (num_rows == DIM_ZERO) ? DIM_WIDTH'(NUM_ROWS) : num_rows;
         cols_r    <= (num_cols == DIM_ZERO) ? DIM_WIDTH'(NUM_COLS) : num_cols;
         hblank_r  <= hblank;
         vblank_r  <= vblank;
         pattern_r <= pattern_sel;
         flat_r    <= flat_value;
      end
   end

   assign dvo         = dvo_r;
   assign dtypeo      = dtype_r;
   assign datao       = data_r;
   assign frame_count = frame_count_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_imager_stream_gen.sv
// Directed self-checking bench for imager_stream_gen.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH       4
`define DTYPE_NONE        4'd0
`define DTYPE_FRAME_START 4'd1
`define DTYPE_FRAME_END   4'd2
`define DTYPE_ROW_START   4'd3
`define DTYPE_ROW_END     4'd4
`define DTYPE_PIXEL       4'd5
`endif

module tb_imager_stream_gen;

   localparam logic [3:0] DT_NO = 4'd0;
   localparam logic [3:0] DT_FS = 4'd1;
   localparam logic [3:0] DT_FE = 4'd2;
   localparam logic [3:0] DT_RS = 4'd3;
   localparam logic [3:0] DT_RE = 4'd4;
   localparam logic [3:0] DT_PX = 4'd5;

   logic                    clk = 1'b0;
   logic                    reset_clk;
   logic                    enable;
   logic [10:0]             num_rows, num_cols;
   logic [15:0]             hblank, vblank;
   logic [1:0]              pattern_sel;
   logic [7:0]              flat_value;
   logic                    dvo;
   logic [`DTYPE_WIDTH-1:0] dtypeo;
   logic [15:0]             datao;
   logic [15:0]             frame_count;
   logic                    busy;

   int n_checks = 0;
   int n_errors = 0;

   logic        exp_dv [0:20];
   logic [3:0]  exp_dt [0:20];
   logic [15:0] exp_da [0:20];

   imager_stream_gen #(
      .PIXEL_WIDTH(8), .DIM_WIDTH(11), .NUM_ROWS(728), .NUM_COLS(1286)
   ) dut (
      .clk(clk), .reset_clk(reset_clk), .enable(enable),
      .num_rows(num_rows), .num_cols(num_cols),
      .hblank(hblank), .vblank(vblank),
      .pattern_sel(pattern_sel), .flat_value(flat_value),
      .dvo(dvo), .dtypeo(dtypeo), .datao(datao),
      .frame_count(frame_count), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      enable    = 1'b0;
      reset_clk = 1'b1;
      tick();
      tick();
      reset_clk = 1'b0;
   endtask

   task automatic setup(input logic [10:0] r, input logic [10:0] c, input logic [15:0] hb,
                        input logic [15:0] vb, input logic [1:0] pat, input logic [7:0] flat);
      num_rows = r; num_cols = c; hblank = hb; vblank = vb;
      pattern_sel = pat; flat_value = flat;
   endtask

   task automatic set_exp(input int c, input logic dv, input logic [3:0] dt, input logic [15:0] da);
      exp_dv[c] = dv; exp_dt[c] = dt; exp_da[c] = da;
   endtask

   initial begin
      int fs_cnt, fe_cnt, pix, col;
      logic found;
      setup(11'd4, 11'd2, 16'd2, 16'd3, 2'd1, 8'h00);

      // Reset state
      do_reset();
      check("rst_dvo", {31'd0, dvo}, 32'd0);
      check("rst_dtype", {28'd0, dtypeo}, 32'd0);
      check("rst_data", {16'd0, datao}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_fcount", {16'd0, frame_count}, 32'd0);

      // 4x2 frame, hblank 2, vblank 3, column ramp: exact cycle timeline
      setup(11'd2, 11'd4, 16'd2, 16'd3, 2'd1, 8'h00);
      set_exp(1, 1'b1, DT_FS, 16'd0);
      set_exp(2, 1'b1, DT_RS, 16'd0);
      for (int k = 0; k < 4; k++) set_exp(3 + k, 1'b1, DT_PX, 16'(k));
      set_exp(7, 1'b1, DT_RE, 16'd0);
      set_exp(8, 1'b0, DT_NO, 16'd0);
      set_exp(9, 1'b0, DT_NO, 16'd0);
      set_exp(10, 1'b1, DT_RS, 16'd0);
      for (int k = 0; k < 4; k++) set_exp(11 + k, 1'b1, DT_PX, 16'(k));
      set_exp(15, 1'b1, DT_RE, 16'd0);
      set_exp(16, 1'b1, DT_FE, 16'd0);
      for (int k = 17; k < 20; k++) set_exp(k, 1'b0, DT_NO, 16'd0);
      set_exp(20, 1'b1, DT_FS, 16'd0);
      enable = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         check($sformatf("tl_c%0d", c), {11'd0, dvo, dtypeo, datao},
               {11'd0, exp_dv[c], exp_dt[c], exp_da[c]});
         if (c == 9)  check("tl_busy_hblank", {31'd0, busy}, 32'd1);
         if (c == 16) check("tl_fcount_fe", {16'd0, frame_count}, 32'd0);
         if (c == 20) check("tl_fcount_next", {16'd0, frame_count}, 32'd1);
      end

      // 1x1 frame with no blanking: 5-cycle period, dvo always high
      do_reset();
      setup(11'd1, 11'd1, 16'd0, 16'd0, 2'd1, 8'h00);
      enable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         check($sformatf("one_dvo_c%0d", c), {31'd0, dvo}, 32'd1);
         case (c % 5)
            0: check($sformatf("one_dt_c%0d", c), {28'd0, dtypeo}, {28'd0, DT_FS});
            1: check($sformatf("one_dt_c%0d", c), {28'd0, dtypeo}, {28'd0, DT_RS});
            2: check($sformatf("one_dt_c%0d", c), {28'd0, dtypeo}, {28'd0, DT_PX});
            3: check($sformatf("one_dt_c%0d", c), {28'd0, dtypeo}, {28'd0, DT_RE});
            default: check($sformatf("one_dt_c%0d", c), {28'd0, dtypeo}, {28'd0, DT_FE});
         endcase
      end

      // Enable dropped during row 0: frame and vblank complete, then idle; row ramp
      do_reset();
      setup(11'd2, 11'd4, 16'd2, 16'd3, 2'd2, 8'h00);
      enable = 1'b1;
      fs_cnt = 0; fe_cnt = 0; pix = 0;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (c == 3) enable = 1'b0;
         if (dvo && dtypeo == DT_FS) fs_cnt++;
         if (dvo && dtypeo == DT_FE) fe_cnt++;
         if (dvo && dtypeo == DT_PX) begin
            if (pix == 0) check("drop_row0_px", {16'd0, datao}, 32'd0);
            if (pix == 4) check("drop_row1_px", {16'd0, datao}, 32'd1);
            pix++;
         end
      end
      check("drop_fs_cnt", 32'(fs_cnt), 32'd1);
      check("drop_fe_cnt", 32'(fe_cnt), 32'd1);
      check("drop_pix_cnt", 32'(pix), 32'd8);
      check("drop_dvo", {31'd0, dvo}, 32'd0);
      check("drop_busy", {31'd0, busy}, 32'd0);
      check("drop_fcount", {16'd0, frame_count}, 32'd1);

      // Flat value changed mid-frame takes effect only on the next frame
      do_reset();
      setup(11'd2, 11'd4, 16'd0, 16'd0, 2'd0, 8'h10);
      enable = 1'b1;
      pix = 0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (c == 4) flat_value = 8'h20;
         if (dvo && dtypeo == DT_PX) begin
            if (pix < 8)
               check($sformatf("flat_f0_p%0d", pix), {16'd0, datao}, 32'h10);
            else if (pix < 16)
               check($sformatf("flat_f1_p%0d", pix), {16'd0, datao}, 32'h20);
            pix++;
         end
      end
      check("flat_enough_px", {31'd0, pix >= 16}, 32'd1);

      // Reset pulse in PIXELS: immediate abort, no FE, FS right after release
      do_reset();
      setup(11'd2, 11'd4, 16'd2, 16'd3, 2'd1, 8'h00);
      enable = 1'b1;
      for (int c = 1; c <= 4; c++) tick();
      check("rp_in_pixels", {12'd0, dtypeo, datao}, {12'd0, DT_PX, 16'd1});
      reset_clk = 1'b1;
      tick();
      reset_clk = 1'b0;
      check("rp_out_zero", {10'd0, dvo, busy, dtypeo, datao}, 32'd0);
      check("rp_fcount", {16'd0, frame_count}, 32'd0);
      tick();
      check("rp_fs_after", {27'd0, dvo, dtypeo}, {27'd0, 1'b1, DT_FS});

      // Moving diagonal, 300 columns: col 257 row 0 frame 2 wraps to 0x03
      do_reset();
      setup(11'd1, 11'd300, 16'd0, 16'd0, 2'd3, 8'h00);
      enable = 1'b1;
      col = 0;
      found = 1'b0;
      for (int c = 0; c < 1200 && !found; c++) begin
         tick();
         if (dvo && dtypeo == DT_RS) col = 0;
         if (dvo && dtypeo == DT_PX) begin
            if (frame_count == 16'd0 && col == 5)
               check("diag_f0_c5", {16'd0, datao}, 32'h05);
            if (frame_count == 16'd1 && col == 299)
               check("diag_f1_c299", {16'd0, datao}, 32'h2c);
            if (frame_count == 16'd2 && col == 257) begin
               check("diag_f2_c257", {16'd0, datao}, 32'h03);
               found = 1'b1;
            end
            col++;
         end
      end
      check("diag_reached", {31'd0, found}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
